rs_output_corrector: RTL
========================

# rs_output_corrector

- Output stage of the RS(15,11) decoder, fed directly by `delay_finished_signal`.
- Buffers received 4-bit symbols in a two-bank codeword store while the decode pipeline runs.
- On the pipeline-aligned finished strobe, applies up to two error corrections to the oldest buffered codeword.
- Streams the corrected symbols out over a valid/ready handshake.

## Interface
- `N_SYM`, 15, symbols per codeword (fixed by RS(15,11)).
- `K_SYM`, 11, message symbols per codeword.
- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `sym_in`  in  4  received symbol, degree-14 symbol first.
- `sym_in_valid`  in  1  `sym_in` is valid this cycle; no backpressure.
- `finished_in`  in  4  from `delay_finished_signal.finished_out`:
  - [0] done strobe.
  - [1] uncorrectable.
  - [3:2] error count 0..2.
- `err_loc0`, `err_loc1`  in  4 each  error position as polynomial degree 0..14; valid with the done strobe.
- `err_val0`, `err_val1`  in  4 each  GF(16) error magnitude; valid with the done strobe.
- `sym_out`  out  4  corrected symbol.
- `sym_out_valid`  out  1  `sym_out` valid.
- `sym_out_ready`  in  1  downstream accepts.
- `sym_out_last`  out  1  final symbol of the codeword.
- `cw_fail`  out  1  current output codeword flagged uncorrectable; constant for the whole codeword.
- `proto_err`  out  1  sticky protocol-violation flag; cleared only by `RESET`.

## Operation
- **Write side**
  - Each `sym_in_valid` cycle writes `sym_in` to `bank[wr_bank][wr_ptr]` and increments `wr_ptr`.
  - At `wr_ptr`=14 the write wraps to 0, marks the bank full and toggles `wr_bank`.
  - Writing into a bank that is still full (not yet emitted) sets `proto_err`; the write still happens.
- **Status queue**
  - Depth 2, one entry per done strobe.
  - Each entry holds fail, count, loc0/val0, loc1/val1, captured on `finished_in[0]`.
  - A strobe while `rd_bank` is not full sets `proto_err` and is ignored.
  - A strobe with the queue already holding 2 entries sets `proto_err` and is dropped.
- **Read FSM**
  - IDLE: `sym_out_valid`=0. Moves to EMIT when the queue is non-empty; pops the head into the active-status register and sets `rd_ptr`=0.
  - EMIT: presents `sym_out` for index `rd_ptr`. Advances on `sym_out_valid & sym_out_ready`.
  - On accepting the last symbol: clear the bank-full flag, toggle `rd_bank`, then go to EMIT again if the queue is non-empty (no bubble), else IDLE.
- **Correction rule**
  - Buffer index i maps to degree 14-i.
  - `sym_out` = stored symbol XOR (val0 if count≥1 and loc0=14-i) XOR (val1 if count=2 and loc1=14-i).
  - GF(16) addition is XOR.
  - If fail=1, no correction is applied and `cw_fail`=1.
  - `err_loc` values above 14 match nothing.
- **Simultaneous events**
  - Done strobe and a pop in the same cycle: the queue count is unchanged and the order is preserved.
  - A write into bank B in the same cycle as B's release is legal (release is seen first).
- **Reset**
  - Async `RESET` mid-codeword drops all stored data and queued status.
  - All outputs are 0 on reset: `sym_out`, `sym_out_valid`, `sym_out_last`, `cw_fail`, `proto_err`.
  - Pointers and bank selects reset to 0.

## Timing
- Done strobe at edge N: `sym_out_valid`=1 with the first symbol after edge N+1 when the FSM is IDLE.
- With `sym_out_ready` held high: one symbol per cycle, 11 (or 15) consecutive cycles.
- Outputs are registered.
- While `sym_out_valid`=1 and `sym_out_ready`=0: `sym_out`, `sym_out_last` and `cw_fail` are held stable.
- `sym_out_last` is high only with the final symbol.
- Back-to-back codewords: the next first symbol follows the last symbol on the very next accept cycle.

## Configuration
- `RS_OUT_PARITY_EN` defined: emits all 15 symbols (degrees 14..0), with corrections applied to parity symbols too; `sym_out_last` is asserted on index 14.
- Undefined: emits only message symbols, indices 0..10 (degrees 14..4). Indices 11..14 are discarded at release; `sym_out_last` is asserted on index 10.

## Test plan
- **Clean codeword**: 15 symbols 0x1..0xF, then strobe `finished_in`=4'b0001.
  - Expect 0x1..0xB out, `cw_fail`=0, `sym_out_last` on 0xB.
  - With `RS_OUT_PARITY_EN`, expect 0x1..0xF instead.
- **Two errors**: same data, strobe 4'b1001 (count 2), loc0=14 val0=0x3, loc1=5 val1=0xA.
  - Expect first symbol 0x1^0x3=0x2 and tenth symbol 0xA^0xA=0x0; all others unchanged.
- **Uncorrectable**: strobe 4'b0011 with nonzero locations/values.
  - Expect raw symbols out and `cw_fail`=1 for all 11.
- **Backpressure and back-to-back**: two codewords written and two strobes queued; toggle `sym_out_ready` 1,0,0,1.
  - Expect data held stable while stalled.
  - Expect the second codeword to start on the accept cycle after the first `sym_out_last`.
- **Protocol errors**:
  - Strobe with only 7 symbols written: expect `proto_err`=1 and no output.
  - Third strobe with 2 entries queued: expect `proto_err`=1 and the entry dropped.
- **Reset mid-EMIT**: assert `RESET` after 4 symbols are output.
  - Expect all outputs 0 immediately.
  - Expect a subsequent fresh codeword to decode correctly.

Source files
------------

// File: rtl/rs_output_corrector.sv
// RS(15,11) output stage: two-bank symbol store, 2-deep status queue, corrected symbols streamed out on valid/ready.
// First symbol registered one edge after the done strobe. All outputs registered. `RS_OUT_PARITY_EN also streams parity.
module rs_output_corrector #(
  parameter int N_SYM = 15,
  parameter int K_SYM = 11
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] sym_in,
  input  logic       sym_in_valid,
  input  logic [3:0] finished_in,
  input  logic [3:0] err_loc0,
  input  logic [3:0] err_loc1,
  input  logic [3:0] err_val0,
  input  logic [3:0] err_val1,
  output logic [3:0] sym_out,
  output logic       sym_out_valid,
  input  logic       sym_out_ready,
  output logic       sym_out_last,
  output logic       cw_fail,
  output logic       proto_err
);

`ifdef RS_OUT_PARITY_EN
  localparam logic [3:0] LAST_IDX = 4'(N_SYM - 1);
`else
  localparam logic [3:0] LAST_IDX = 4'(K_SYM - 1);
`endif
  localparam logic [3:0] WR_LAST = 4'(N_SYM - 1);

  typedef struct packed {
    logic       fail;
    logic [1:0] cnt;
    logic [3:0] loc0;
    logic [3:0] val0;
    logic [3:0] loc1;
    logic [3:0] val1;
  } status_t;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  logic [3:0] bank_q [2][N_SYM];
  logic [3:0] wr_ptr_q, rd_ptr_q;
  logic       wr_bank_q, rd_bank_q;
  logic [1:0] full_q, full_d;
  status_t    sq_q [2];
  logic       sq_head_q;
  logic [1:0] sq_cnt_q;
  status_t    act_q;
  state_t     state_q;
  logic [3:0] sym_out_q;
  logic       sym_out_valid_q, sym_out_last_q, cw_fail_q, proto_err_q;

  status_t    strobe_st, head_st;
  logic       accept, at_last, release_w, pop, push, strobe_bad, wr_full_hit;
  logic       next_bank, push_slot;
  logic [3:0] nxt_ptr, load_sym, next_sym;

  // Buffer index i holds the coefficient of degree 14-i; fail suppresses all correction.
  function automatic logic [3:0] correct(input logic [3:0] s, input status_t st, input logic [3:0] idx);
    logic [3:0] deg;
    logic [3:0] r;
    deg = WR_LAST - idx;
    r   = s;
    if (!st.fail) begin
      if (st.cnt != 2'd0 && st.loc0 == deg) r = r ^ st.val0;
      if (st.cnt == 2'd2 && st.loc1 == deg) r = r ^ st.val1;
    end
    return r;
  endfunction

  assign strobe_st   = '{fail: finished_in[1], cnt: finished_in[3:2],
                         loc0: err_loc0, val0: err_val0, loc1: err_loc1, val1: err_val1};
  assign head_st     = sq_q[sq_head_q];
  assign accept      = sym_out_valid_q & sym_out_ready;
  assign at_last     = (rd_ptr_q == LAST_IDX);
  assign release_w   = (state_q == S_EMIT) & accept & at_last;
  assign pop         = (sq_cnt_q != 2'd0) & ((state_q == S_IDLE) | release_w);
  assign push        = finished_in[0] & full_q[rd_bank_q] & (sq_cnt_q != 2'd2);
  assign strobe_bad  = finished_in[0] & ~push;
  // Release of the bank being written in the same cycle is seen before the write.
  assign wr_full_hit = sym_in_valid & full_q[wr_bank_q] & ~(release_w & (rd_bank_q == wr_bank_q));
  assign push_slot   = sq_head_q ^ sq_cnt_q[0];
  assign next_bank   = release_w ? ~rd_bank_q : rd_bank_q;
  assign nxt_ptr     = at_last ? 4'd0 : rd_ptr_q + 4'd1;
  assign load_sym    = correct(bank_q[next_bank][0], head_st, 4'd0);
  assign next_sym    = correct(bank_q[rd_bank_q][nxt_ptr], act_q, nxt_ptr);

  always_comb begin
    full_d = full_q;
    if (release_w) full_d[rd_bank_q] = 1'b0;
    if (sym_in_valid && wr_ptr_q == WR_LAST) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (sym_in_valid) bank_q[wr_bank_q][wr_ptr_q] <= sym_in;
    if (push) sq_q[push_slot] <= strobe_st;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      full_q          <= '0;
      sq_head_q       <= 1'b0;
      sq_cnt_q        <= '0;
      act_q           <= '0;
      state_q         <= S_IDLE;
      sym_out_q       <= '0;
      sym_out_valid_q <= 1'b0;
      sym_out_last_q  <= 1'b0;
      cw_fail_q       <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      if (sym_in_valid) begin
        if (wr_ptr_q == WR_LAST) begin
          wr_ptr_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_ptr_q <= wr_ptr_q + 4'd1;
        end
      end
      full_q <= full_d;
      if (wr_full_hit || strobe_bad) proto_err_q <= 1'b1;

      if (pop) sq_head_q <= ~sq_head_q;
      if (push && !pop)      sq_cnt_q <= sq_cnt_q + 2'd1;
      else if (pop && !push) sq_cnt_q <= sq_cnt_q - 2'd1;

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            act_q           <= head_st;
            rd_ptr_q        <= '0;
            sym_out_q       <= load_sym;
            sym_out_valid_q <= 1'b1;
            sym_out_last_q  <= 1'b0;
            cw_fail_q       <= head_st.fail;
            state_q         <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (accept) begin
            if (at_last) begin
              rd_bank_q <= ~rd_bank_q;
              if (pop) begin
                act_q          <= head_st;
                rd_ptr_q       <= '0;
                sym_out_q      <= load_sym;
                sym_out_last_q <= 1'b0;
                cw_fail_q      <= head_st.fail;
              end else begin
                rd_ptr_q        <= '0;
                sym_out_q       <= '0;
                sym_out_valid_q <= 1'b0;
                sym_out_last_q  <= 1'b0;
                cw_fail_q       <= 1'b0;
                state_q         <= S_IDLE;
              end
            end else begin
              rd_ptr_q       <= nxt_ptr;
              sym_out_q      <= next_sym;
              sym_out_last_q <= (nxt_ptr == LAST_IDX);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sym_out       = sym_out_q;
  assign sym_out_valid = sym_out_valid_q;
  assign sym_out_last  = sym_out_last_q;
  assign cw_fail       = cw_fail_q;
  assign proto_err     = proto_err_q;

endmodule
